// File: rtl/result_scoreboard.sv
// Self-checking result scoreboard: compares a stream of DUT results against a
// loadable table of expected values under a mask and reports pass/fail counts.
module result_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned AW     = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_en,
  input  logic [AW-1:0]     load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic [AW-1:0]     first_idx,
  input  logic [AW:0]       num_tests,
  input  logic [DATA_W-1:0] cmp_mask,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic              busy,
  output logic              done,
  output logic [AW:0]       pass_count,
  output logic [AW:0]       fail_count,
  output logic              all_pass,
  output logic              err_flag,
  output logic [AW-1:0]     fail_idx,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got
);

  localparam logic [AW:0]   DepthCnt = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CntOne   = (AW+1)'(1);
  localparam logic [AW-1:0] IdxOne   = AW'(1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q;
  logic [AW-1:0]     idx_q;
  logic [AW:0]       remaining_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              accepting;
  logic [AW:0]       run_len;
  logic [DATA_W-1:0] cur_exp;
  logic              mismatch;
  logic [AW:0]       pass_next;
  logic [AW:0]       fail_next;
  logic              last_cmp;

  always_comb begin
    accepting = (state_q != StRun);
    run_len   = (num_tests > DepthCnt) ? DepthCnt : num_tests;
    cur_exp   = mem[idx_q];
    mismatch  = |((res_data ^ cur_exp) & mask_q);
    pass_next = pass_count + {{AW{1'b0}}, ~mismatch};
    fail_next = fail_count + {{AW{1'b0}}, mismatch};
    last_cmp  = (remaining_q == CntOne);
  end

  // Table has no reset; a load coinciding with start lands before any compare reads it.
  always_ff @(posedge clock) begin
    if (load_en && accepting) begin
      mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      remaining_q <= '0;
      mask_q      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass_count  <= '0;
      fail_count  <= '0;
      all_pass    <= 1'b0;
      err_flag    <= 1'b0;
      fail_idx    <= '0;
      fail_exp    <= '0;
      fail_got    <= '0;
    end else begin
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            idx_q       <= first_idx;
            mask_q      <= cmp_mask;
            remaining_q <= run_len;
            pass_count  <= '0;
            fail_count  <= '0;
            err_flag    <= 1'b0;
            fail_idx    <= '0;
            fail_exp    <= '0;
            fail_got    <= '0;
            if (run_len == '0) begin
              state_q  <= StDone;
              busy     <= 1'b0;
              done     <= 1'b1;
              all_pass <= 1'b1;
            end else begin
              state_q  <= StRun;
              busy     <= 1'b1;
              done     <= 1'b0;
              all_pass <= 1'b0;
            end
          end
        end
        StRun: begin
          if (res_valid) begin
            pass_count  <= pass_next;
            fail_count  <= fail_next;
            idx_q       <= idx_q + IdxOne;
            remaining_q <= remaining_q - CntOne;
            if (mismatch && !err_flag) begin
              err_flag <= 1'b1;
              fail_idx <= idx_q;
              fail_exp <= cur_exp;
              fail_got <= res_data;
            end
            // Final compare retires straight into DONE so counts and done appear together.
            if (last_cmp) begin
              state_q  <= StDone;
              busy     <= 1'b0;
              done     <= 1'b1;
              all_pass <= (fail_next == '0);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_result_scoreboard.sv
// Bench for result_scoreboard: directed plan cases plus randomized runs checked
// against an array-based reference of the expected table.
module tb_result_scoreboard;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int AW     = 5;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              load_en = 1'b0;
  logic [AW-1:0]     load_addr = '0;
  logic [DATA_W-1:0] load_data = '0;
  logic              start = 1'b0;
  logic [AW-1:0]     first_idx = '0;
  logic [AW:0]       num_tests = '0;
  logic [DATA_W-1:0] cmp_mask = '0;
  logic              res_valid = 1'b0;
  logic [DATA_W-1:0] res_data = '0;
  logic              busy, done, all_pass, err_flag;
  logic [AW:0]       pass_count, fail_count;
  logic [AW-1:0]     fail_idx;
  logic [DATA_W-1:0] fail_exp, fail_got;

  result_scoreboard #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .first_idx(first_idx), .num_tests(num_tests),
    .cmp_mask(cmp_mask), .res_valid(res_valid), .res_data(res_data), .busy(busy),
    .done(done), .pass_count(pass_count), .fail_count(fail_count), .all_pass(all_pass),
    .err_flag(err_flag), .fail_idx(fail_idx), .fail_exp(fail_exp), .fail_got(fail_got)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] model_mem [DEPTH];
  logic [31:0] feed [DEPTH];
  logic [31:0] plan_tbl [20] = '{
    32'h00000000, 32'h00000001, 32'h00000002, 32'h00000004, 32'h00000005,
    32'h00000007, 32'h00000008, 32'h0000000b, 32'h00000003, 32'hfffffffe,
    32'h00000000, 32'h00000005, 32'h00000001, 32'hfffffff4, 32'h000004d2,
    32'hfffff8d7, 32'h00000001, 32'hfffffb2c, 32'h00000030, 32'h00000030};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int addr, input logic [31:0] data);
    @(negedge clock);
    load_en = 1'b1; load_addr = addr[AW-1:0]; load_data = data;
    @(negedge clock);
    load_en = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".pass"}, pass_count, 0);
    check({tag, ".fail"}, fail_count, 0);
    check({tag, ".all_pass"}, all_pass, 0);
    check({tag, ".err"}, err_flag, 0);
    check({tag, ".fidx"}, fail_idx, 0);
    check({tag, ".fexp"}, fail_exp, 0);
    check({tag, ".fgot"}, fail_got, 0);
  endtask

  // Runs one check pass: feed[0..n-1] as results; optional gaps, mid-run pokes
  // (load + restart, both must be ignored) and a load coinciding with start.
  task automatic run_check(input string tag, input int first, input int num,
                           input logic [31:0] mask, input int gap_pct, input bit poke,
                           input bit co_load);
    int n, exp_pass, exp_fail, a;
    logic [AW-1:0] e_idx;
    logic [31:0] e_exp, e_got;
    n = (num > DEPTH) ? DEPTH : num;
    exp_pass = 0; exp_fail = 0; e_idx = '0; e_exp = '0; e_got = '0;
    if (co_load) model_mem[first] = feed[0];
    for (int i = 0; i < n; i++) begin
      a = (first + i) % DEPTH;
      if (((feed[i] ^ model_mem[a]) & mask) == 0) exp_pass++;
      else begin
        if (exp_fail == 0) begin
          e_idx = a[AW-1:0]; e_exp = model_mem[a]; e_got = feed[i];
        end
        exp_fail++;
      end
    end
    @(negedge clock);
    start = 1'b1; first_idx = first[AW-1:0]; num_tests = num[AW:0]; cmp_mask = mask;
    if (co_load) begin
      load_en = 1'b1; load_addr = first[AW-1:0]; load_data = feed[0];
    end
    @(negedge clock);
    start = 1'b0; load_en = 1'b0;
    if (n == 0) begin
      check({tag, ".zero.done"}, done, 1);
      check({tag, ".zero.all_pass"}, all_pass, 1);
      check({tag, ".zero.busy"}, busy, 0);
      check({tag, ".zero.pass"}, pass_count, 0);
      return;
    end
    check({tag, ".busy"}, busy, 1);
    check({tag, ".done_early"}, done, 0);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(99) < gap_pct) begin
        res_valid = 1'b0; res_data = $urandom;
        @(negedge clock);
      end
      res_valid = 1'b1; res_data = feed[i];
      if (poke && i == 1) begin
        a = (first + 2) % DEPTH;
        load_en = 1'b1; load_addr = a[AW-1:0]; load_data = ~model_mem[a];
        start = 1'b1; first_idx = '0; num_tests = 1; cmp_mask = '0;
      end
      @(negedge clock);
      res_valid = 1'b0; load_en = 1'b0; start = 1'b0;
      if (i == 0) check({tag, ".latency"}, pass_count + fail_count, 1);
      if (i == n - 2) check({tag, ".not_done"}, done, 0);
    end
    check({tag, ".done"}, done, 1);
    check({tag, ".busy_end"}, busy, 0);
    check({tag, ".pass"}, pass_count, exp_pass);
    check({tag, ".fail"}, fail_count, exp_fail);
    check({tag, ".all_pass"}, all_pass, exp_fail == 0);
    check({tag, ".err"}, err_flag, exp_fail != 0);
    check({tag, ".fidx"}, fail_idx, e_idx);
    check({tag, ".fexp"}, fail_exp, e_exp);
    check({tag, ".fgot"}, fail_got, e_got);
    res_valid = 1'b1; res_data = $urandom;
    @(negedge clock);
    res_valid = 1'b0;
    check({tag, ".hold_pass"}, pass_count + fail_count, exp_pass + exp_fail);
    check({tag, ".hold_done"}, done, 1);
  endtask

  initial begin
    #2;
    check_idle_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) load(i, plan_tbl[i]);
    for (int i = 0; i < 19; i++) feed[i] = plan_tbl[i + 1];
    run_check("plan_all_pass", 1, 19, 32'hffffffff, 0, 0, 0);

    feed[8] = 32'hfffffffc;
    feed[11] = 32'h00000000;
    run_check("plan_two_fail", 1, 19, 32'hffffffff, 0, 0, 0);

    feed[0] = 32'hffff0005;
    run_check("mask_low", 4, 1, 32'h0000ffff, 0, 0, 0);

    load(30, 32'h0000000a); load(31, 32'h0000000b);
    load(0, 32'h0000000c);  load(1, 32'h0000000d);
    for (int i = 0; i < 4; i++) feed[i] = model_mem[(30 + i) % DEPTH];
    run_check("wrap", 30, 4, 32'hffffffff, 0, 0, 0);

    load(0, plan_tbl[0]); load(1, plan_tbl[1]);
    for (int i = 0; i < 19; i++) feed[i] = plan_tbl[i + 1];
    run_check("gaps_poke", 1, 19, 32'hffffffff, 50, 1, 0);

    load(7, 32'h12345678);
    feed[0] = 32'hcafef00d;
    run_check("co_load", 7, 1, 32'hffffffff, 0, 0, 1);

    run_check("zero_len", 3, 0, 32'hffffffff, 0, 0, 0);

    // Asynchronous reset mid-run after five results.
    @(negedge clock);
    start = 1'b1; first_idx = '0; num_tests = 10; cmp_mask = '1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      res_valid = 1'b1; res_data = (i == 2) ? 32'hdeadbeef : model_mem[i];
      @(negedge clock);
    end
    res_valid = 1'b0;
    check("pre_abort.count", pass_count + fail_count, 5);
    #2 reset = 1'b1;
    #1 check_idle_zero("abort");
    @(negedge clock);
    reset = 1'b0;
    res_valid = 1'b1; res_data = $urandom;
    @(negedge clock);
    res_valid = 1'b0;
    check("post_abort.idle_busy", busy, 0);
    check("post_abort.idle_pass", pass_count, 0);

    for (int iter = 0; iter < 20; iter++) begin
      int f, nt, nn;
      logic [31:0] m;
      for (int k = 0; k < 4; k++) load($urandom_range(DEPTH - 1), $urandom);
      f = $urandom_range(DEPTH - 1);
      nt = $urandom_range(40);
      m = ($urandom_range(1) == 1) ? 32'hffffffff : $urandom;
      nn = (nt > DEPTH) ? DEPTH : nt;
      for (int i = 0; i < nn; i++) begin
        feed[i] = model_mem[(f + i) % DEPTH];
        if ($urandom_range(9) < 2) feed[i] = feed[i] ^ (32'h1 << $urandom_range(31));
      end
      run_check($sformatf("rand%0d", iter), f, nt, m, 30, $urandom_range(1) == 1, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
